// File: rtl/mips_boot_pkg.sv
// Shared types and defaults for the iitk_mini_mips boot/run sequencer.
package mips_boot_pkg;

  localparam int unsigned ADDR_W_DEFAULT    = 12;
  localparam int unsigned DATA_W_DEFAULT    = 32;
  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } boot_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count up on enable, stick at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a streamed program into iitk_mini_mips instruction memory, runs the
// core, and stops it on reaching the end PC or when the cycle budget runs out.
module imem_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W    = DATA_W_DEFAULT,
  parameter logic [31:0] TEXT_BASE = TEXT_BASE_DEFAULT,
  parameter int unsigned CYC_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_count,
  input  logic [CYC_W-1:0]  max_cycles,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [31:0]       pc_out,
  output logic              core_reset,
  output logic              init_mode,
  output logic              write_enable,
  output logic [ADDR_W-1:0] init_address,
  output logic [DATA_W-1:0] init_instruction,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CYC_W-1:0]  run_cycles
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned RC_W  = CYC_W + 1;
  localparam logic [CNT_W-1:0] MAX_COUNT = CNT_W'(1) << ADDR_W;

  boot_state_e       r_state,  w_nx_state;
  logic              r_in_ready, w_nx_in_ready;
  logic              r_core_reset, w_nx_core_reset;
  logic              r_init_mode, w_nx_init_mode;
  logic              r_we, w_nx_we;
  logic [ADDR_W-1:0] r_init_address, w_nx_addr;
  logic [DATA_W-1:0] r_init_instruction, w_nx_data;
  logic              r_busy, w_nx_busy;
  logic              r_done, w_nx_done;
  logic              r_timeout, w_nx_timeout;
  logic [CNT_W-1:0]  r_index, w_nx_index;
  logic [CNT_W-1:0]  r_count, w_nx_count;
  logic [CYC_W-1:0]  r_max_cycles, w_nx_max;

  logic              w_cnt_clear;
  logic              w_cnt_en;
  logic [CYC_W-1:0]  w_run_cycles;
  logic [RC_W-1:0]   w_run_next;
  logic [CNT_W-1:0]  w_count_clamped;
  logic [CNT_W-1:0]  w_index_inc;
  logic [31:0]       w_end_pc;
  logic              w_handshake;

  assign w_count_clamped = (load_count > MAX_COUNT) ? MAX_COUNT : load_count;
  assign w_index_inc     = r_index + CNT_W'(1);
  assign w_end_pc        = TEXT_BASE + (32'(r_count) << 2);
  assign w_handshake     = in_valid && r_in_ready;
  assign w_run_next      = {1'b0, w_run_cycles} + RC_W'(1);
  // Only cycles in which the core is actually out of reset are counted.
  assign w_cnt_en        = (r_state == ST_RUN) && !r_core_reset;

  sat_counter #(.W(CYC_W)) u_run_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (w_cnt_clear),
    .i_en    (w_cnt_en),
    .o_count (w_run_cycles)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= ST_IDLE;
      r_in_ready         <= 1'b0;
      r_core_reset       <= 1'b1;
      r_init_mode        <= 1'b1;
      r_we               <= 1'b0;
      r_init_address     <= '0;
      r_init_instruction <= '0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_timeout          <= 1'b0;
      r_index            <= '0;
      r_count            <= '0;
      r_max_cycles       <= '0;
    end else begin
      r_state            <= w_nx_state;
      r_in_ready         <= w_nx_in_ready;
      r_core_reset       <= w_nx_core_reset;
      r_init_mode        <= w_nx_init_mode;
      r_we               <= w_nx_we;
      r_init_address     <= w_nx_addr;
      r_init_instruction <= w_nx_data;
      r_busy             <= w_nx_busy;
      r_done             <= w_nx_done;
      r_timeout          <= w_nx_timeout;
      r_index            <= w_nx_index;
      r_count            <= w_nx_count;
      r_max_cycles       <= w_nx_max;
    end
  end

  // Next state and next output values.
  always_comb begin
    w_nx_state      = r_state;
    w_nx_in_ready   = r_in_ready;
    w_nx_core_reset = r_core_reset;
    w_nx_init_mode  = r_init_mode;
    w_nx_we         = 1'b0;
    w_nx_addr       = r_init_address;
    w_nx_data       = r_init_instruction;
    w_nx_done       = r_done;
    w_nx_timeout    = r_timeout;
    w_nx_index      = r_index;
    w_nx_count      = r_count;
    w_nx_max        = r_max_cycles;
    w_cnt_clear     = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        w_nx_core_reset = 1'b1;
        w_nx_init_mode  = 1'b1;
        w_nx_in_ready   = 1'b0;
        if (start && (load_count != '0)) begin
          w_nx_state    = ST_LOAD;
          w_nx_in_ready = 1'b1;
          w_nx_done     = 1'b0;
          w_nx_timeout  = 1'b0;
          w_nx_index    = '0;
          w_nx_count    = w_count_clamped;
          w_nx_max      = max_cycles;
          w_cnt_clear   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_handshake) begin
          w_nx_we    = 1'b1;
          w_nx_addr  = ADDR_W'(r_index);
          w_nx_data  = in_data;
          w_nx_index = w_index_inc;
          if (w_index_inc == r_count) begin
            w_nx_in_ready = 1'b0;
            w_nx_state    = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        w_nx_init_mode  = 1'b0;
        w_nx_core_reset = 1'b1;
        w_nx_state      = ST_RUN;
      end
      ST_RUN: begin
        w_nx_core_reset = 1'b0;
        w_nx_init_mode  = 1'b0;
        if (!r_core_reset) begin
          // Halt takes priority over an expiring budget.
          if (pc_out == w_end_pc) begin
            w_nx_state      = ST_DONE;
            w_nx_done       = 1'b1;
            w_nx_core_reset = 1'b1;
            w_nx_init_mode  = 1'b1;
          end else if ((r_max_cycles != '0) && (w_run_next == {1'b0, r_max_cycles})) begin
            w_nx_state      = ST_DONE;
            w_nx_timeout    = 1'b1;
            w_nx_core_reset = 1'b1;
            w_nx_init_mode  = 1'b1;
          end
        end
      end
      default: begin
        w_nx_state = ST_IDLE;
      end
    endcase

    w_nx_busy = (w_nx_state == ST_LOAD) || (w_nx_state == ST_SETTLE) ||
                (w_nx_state == ST_RUN);
  end

  assign in_ready         = r_in_ready;
  assign core_reset       = r_core_reset;
  assign init_mode        = r_init_mode;
  assign write_enable     = r_we;
  assign init_address     = r_init_address;
  assign init_instruction = r_init_instruction;
  assign busy             = r_busy;
  assign done             = r_done;
  assign timeout          = r_timeout;
  assign run_cycles       = w_run_cycles;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a simple PC-stepping core model.
module tb_imem_boot_loader;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CYC_W  = 16;
  localparam logic [31:0] BASE   = 32'h0040_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   load_count;
  logic [CYC_W-1:0]  max_cycles;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [31:0]       pc_out = BASE;
  logic              core_reset;
  logic              init_mode;
  logic              write_enable;
  logic [ADDR_W-1:0] init_address;
  logic [DATA_W-1:0] init_instruction;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CYC_W-1:0]  run_cycles;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] prog [4];
  logic        pc_stuck = 1'b0;
  int          cyc_cnt = 0;
  int          wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];
  logic        prev_im = 1'b1;
  logic        prev_cr = 1'b1;
  int          im_fall_cyc = -1;
  int          cr_fall_cyc = -1;

  imem_boot_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TEXT_BASE(BASE), .CYC_W(CYC_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .load_count       (load_count),
    .max_cycles       (max_cycles),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .pc_out           (pc_out),
    .core_reset       (core_reset),
    .init_mode        (init_mode),
    .write_enable     (write_enable),
    .init_address     (init_address),
    .init_instruction (init_instruction),
    .busy             (busy),
    .done             (done),
    .timeout          (timeout),
    .run_cycles       (run_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  // Core model: PC advances by 4 in every cycle the core is out of reset.
  always @(negedge clk) begin
    if (core_reset || pc_stuck) pc_out <= BASE;
    else                        pc_out <= pc_out + 32'd4;
  end

  // Log instruction-memory writes and control edges.
  always @(negedge clk) begin
    if (write_enable) begin
      wr_addr_q.push_back(int'(init_address));
      wr_data_q.push_back(init_instruction);
      wr_cyc_q.push_back(cyc_cnt);
    end
    if (prev_im && !init_mode)  im_fall_cyc = cyc_cnt;
    if (prev_cr && !core_reset) cr_fall_cyc = cyc_cnt;
    prev_im = init_mode;
    prev_cr = core_reset;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    im_fall_cyc = -1;
    cr_fall_cyc = -1;
  endtask

  task automatic do_start(input int lc, input int mc);
    start      = 1'b1;
    load_count = (ADDR_W+1)'(lc);
    max_cycles = CYC_W'(mc);
    tick();
    start      = 1'b0;
  endtask

  // Offer words prog[first..last] following a repeating valid pattern.
  task automatic stream(input int first, input int last, input logic [15:0] pat, input int pat_len);
    int  idx;
    int  cyc;
    bit  hs;
    idx = first;
    cyc = 0;
    while (idx <= last && cyc < 64) begin
      in_valid = pat[cyc % pat_len];
      in_data  = prog[idx];
      hs       = in_valid && in_ready;
      tick();
      if (hs) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (idx <= last) check_eq("stream_stalled", 64'(idx), 64'(last + 1));
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || timeout) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check_eq("wait_end_expired", 64'(done | timeout), 64'd1);
  endtask

  initial begin
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_000A;
    prog[2] = 32'h0109_5020;
    prog[3] = 32'hAC0A_0000;

    reset      = 1'b1;
    start      = 1'b0;
    load_count = '0;
    max_cycles = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    tick();
    tick();
    check_eq("rst_core_reset", 64'(core_reset), 64'd1);
    check_eq("rst_init_mode",  64'(init_mode),  64'd1);
    check_eq("rst_in_ready",   64'(in_ready),   64'd0);
    check_eq("rst_busy",       64'(busy),       64'd0);
    check_eq("rst_we",         64'(write_enable), 64'd0);
    check_eq("rst_run_cycles", 64'(run_cycles), 64'd0);
    reset = 1'b0;
    tick();

    // Three-word program, continuous stream.
    clear_log();
    do_start(3, 0);
    check_eq("t1_in_ready_after_start", 64'(in_ready), 64'd1);
    check_eq("t1_busy", 64'(busy), 64'd1);
    stream(0, 2, 16'hFFFF, 16);
    check_eq("t1_in_ready_drop", 64'(in_ready), 64'd0);
    wait_end();
    check_eq("t1_nwrites", 64'(wr_addr_q.size()), 64'd3);
    if (wr_addr_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("t1_addr%0d", i), 64'(wr_addr_q[i]), 64'(i));
        check_eq($sformatf("t1_data%0d", i), 64'(wr_data_q[i]), 64'(prog[i]));
      end
      check_eq("t1_consecutive", 64'(wr_cyc_q[2] - wr_cyc_q[0]), 64'd2);
      check_eq("t1_init_mode_fall", 64'(im_fall_cyc), 64'(wr_cyc_q[2] + 1));
      check_eq("t1_core_reset_fall", 64'(cr_fall_cyc), 64'(wr_cyc_q[2] + 2));
    end
    check_eq("t1_done",       64'(done),       64'd1);
    check_eq("t1_timeout",    64'(timeout),    64'd0);
    check_eq("t1_run_cycles", 64'(run_cycles), 64'd3);
    check_eq("t1_core_reset", 64'(core_reset), 64'd1);
    check_eq("t1_init_mode",  64'(init_mode),  64'd1);
    check_eq("t1_busy_end",   64'(busy),       64'd0);

    // Stream with gaps: valid = 1,0,0,1,0,1.
    clear_log();
    do_start(3, 0);
    check_eq("t2_done_cleared", 64'(done), 64'd0);
    stream(0, 2, 16'h0029, 6);
    wait_end();
    check_eq("t2_nwrites", 64'(wr_addr_q.size()), 64'd3);
    if (wr_addr_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("t2_addr%0d", i), 64'(wr_addr_q[i]), 64'(i));
        check_eq($sformatf("t2_data%0d", i), 64'(wr_data_q[i]), 64'(prog[i]));
      end
      check_eq("t2_gap01", 64'(wr_cyc_q[1] - wr_cyc_q[0]), 64'd3);
      check_eq("t2_gap12", 64'(wr_cyc_q[2] - wr_cyc_q[1]), 64'd2);
    end
    check_eq("t2_done", 64'(done), 64'd1);

    // Budget expiry with a stuck PC.
    pc_stuck = 1'b1;
    do_start(3, 5);
    stream(0, 2, 16'hFFFF, 16);
    wait_end();
    check_eq("t3_timeout",    64'(timeout),    64'd1);
    check_eq("t3_done",       64'(done),       64'd0);
    check_eq("t3_run_cycles", 64'(run_cycles), 64'd5);
    check_eq("t3_core_reset", 64'(core_reset), 64'd1);
    pc_stuck = 1'b0;
    tick();

    // Halt lands on the last budgeted cycle.
    do_start(3, 3);
    stream(0, 2, 16'hFFFF, 16);
    wait_end();
    check_eq("t4_done",       64'(done),       64'd1);
    check_eq("t4_timeout",    64'(timeout),    64'd0);
    check_eq("t4_run_cycles", 64'(run_cycles), 64'd3);

    // Zero-count start is ignored; start during LOAD is ignored.
    do_start(0, 0);
    check_eq("t5_zero_busy",     64'(busy),     64'd0);
    check_eq("t5_zero_in_ready", 64'(in_ready), 64'd0);
    check_eq("t5_zero_done",     64'(done),     64'd1);
    clear_log();
    do_start(3, 0);
    stream(0, 0, 16'hFFFF, 16);
    do_start(7, 2);
    check_eq("t5_busy_start_in_ready", 64'(in_ready), 64'd1);
    stream(1, 2, 16'hFFFF, 16);
    check_eq("t5_in_ready_drop", 64'(in_ready), 64'd0);
    wait_end();
    check_eq("t5_nwrites",    64'(wr_addr_q.size()), 64'd3);
    check_eq("t5_done",       64'(done),       64'd1);
    check_eq("t5_timeout",    64'(timeout),    64'd0);
    check_eq("t5_run_cycles", 64'(run_cycles), 64'd3);

    // Reset in the middle of a four-word load.
    do_start(4, 0);
    stream(0, 1, 16'hFFFF, 16);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_in_ready",   64'(in_ready),         64'd0);
    check_eq("t6_busy",       64'(busy),             64'd0);
    check_eq("t6_we",         64'(write_enable),     64'd0);
    check_eq("t6_core_reset", 64'(core_reset),       64'd1);
    check_eq("t6_init_mode",  64'(init_mode),        64'd1);
    check_eq("t6_addr",       64'(init_address),     64'd0);
    check_eq("t6_data",       64'(init_instruction), 64'd0);
    check_eq("t6_done",       64'(done),             64'd0);
    check_eq("t6_run_cycles", 64'(run_cycles),       64'd0);
    tick();
    clear_log();
    do_start(2, 0);
    stream(2, 3, 16'hFFFF, 16);
    wait_end();
    check_eq("t6_nwrites", 64'(wr_addr_q.size()), 64'd2);
    if (wr_addr_q.size() == 2) begin
      check_eq("t6_reload_addr0", 64'(wr_addr_q[0]), 64'd0);
      check_eq("t6_reload_data0", 64'(wr_data_q[0]), 64'(prog[2]));
      check_eq("t6_reload_addr1", 64'(wr_addr_q[1]), 64'd1);
    end
    check_eq("t6_done_run", 64'(done),       64'd1);
    check_eq("t6_run_cyc",  64'(run_cycles), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
